sram_axi_bridge: RTL and testbench

Converts the CPU core's two SRAM-like request/response ports (instruction and data) into a single AXI3 master port, 32-bit, single-beat transfers only. Sits directly downstream of the CPU top: the core's inst/data `req/addr_ok/data_ok` ports terminate here, and the AXI side goes to the SoC interconnect. It arbitrates read addresses, serialises writes, routes read responses by ID, and orders data-port transactions.

---
 rtl/sram_axi_bridge_pkg.sv | 13 +
 rtl/sram_axi_bridge.sv | 184 ++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_axi_bridge_pkg.sv
// Shared constants for the SRAM-to-AXI3 bridge: AXI IDs, burst type and FSM encodings.
package sram_axi_bridge_pkg;
  localparam logic [3:0] AXI_ID_INST    = 4'd0;
  localparam logic [3:0] AXI_ID_DATA    = 4'd1;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [0:0] AR_IDLE = 1'b0;
  localparam logic [0:0] AR_BUSY = 1'b1;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_SEND = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
endpackage

// File: rtl/sram_axi_bridge.sv
// Bridges the core's inst/data SRAM-like ports onto one single-beat AXI3 master.
// At most one inst read and one data transaction are in flight at any time.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  logic [0:0] ar_state;
  logic [1:0] w_state;
  logic       inst_outstanding, data_outstanding;
  logic       aw_done, w_done;
  logic       ar_idle, data_rd_acc, data_wr_acc, inst_acc;
  logic       inst_rsp, data_rrsp, b_done, aw_fin, w_fin;

  // Write-side, error and burst-end inputs carry no information for single-beat traffic.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bid, bresp};

  assign arlen   = 8'd0;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awid    = AXI_ID_DATA;
  assign awlen   = 8'd0;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = AXI_ID_DATA;
  assign wlast   = 1'b1;
  assign rready  = 1'b1;
  assign bready  = 1'b1;

  assign ar_idle     = (ar_state == AR_IDLE);
  assign data_rd_acc = data_sram_req && !data_sram_wr && ar_idle && !data_outstanding;
  assign data_wr_acc = data_sram_req && data_sram_wr && (w_state == W_IDLE) && !data_outstanding;
  // Data reads win the AR slot; inst waits until its own previous read has returned.
  assign inst_acc    = inst_sram_req && ar_idle && !data_rd_acc && !inst_outstanding;

  assign inst_sram_addr_ok = inst_acc;
  assign data_sram_addr_ok = data_rd_acc || data_wr_acc;

  assign inst_rsp  = rvalid && (rid == AXI_ID_INST);
  assign data_rrsp = rvalid && (rid == AXI_ID_DATA);
  assign b_done    = (w_state == W_RESP) && bvalid;

  assign inst_sram_data_ok = inst_rsp;
  assign inst_sram_rdata   = rdata;
  assign data_sram_data_ok = data_rrsp || b_done;
  assign data_sram_rdata   = rdata;

  assign arvalid = (ar_state == AR_BUSY);
  assign awvalid = (w_state == W_SEND) && !aw_done;
  assign wvalid  = (w_state == W_SEND) && !w_done;
  assign aw_fin  = aw_done || awready;
  assign w_fin   = w_done || wready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_state <= AR_IDLE;
      araddr   <= '0;
      arid     <= '0;
      arsize   <= '0;
    end else begin
      case (ar_state)
        AR_IDLE: begin
          if (data_rd_acc) begin
            araddr   <= data_sram_addr;
            arid     <= AXI_ID_DATA;
            arsize   <= {1'b0, data_sram_size};
            ar_state <= AR_BUSY;
          end else if (inst_acc) begin
            araddr   <= inst_sram_addr;
            arid     <= AXI_ID_INST;
            arsize   <= {1'b0, inst_sram_size};
            ar_state <= AR_BUSY;
          end
        end
        AR_BUSY: if (arready) ar_state <= AR_IDLE;
        default: ar_state <= AR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      awaddr  <= '0;
      awsize  <= '0;
      wdata   <= '0;
      wstrb   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (data_wr_acc) begin
          awaddr  <= data_sram_addr;
          awsize  <= {1'b0, data_sram_size};
          wdata   <= data_sram_wdata;
          wstrb   <= data_sram_wstrb;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          w_state <= W_SEND;
        end
        W_SEND: begin
          if (awready) aw_done <= 1'b1;
          if (wready)  w_done  <= 1'b1;
          // Leave in the cycle of the last handshake so an immediate bvalid is not missed.
          if (aw_fin && w_fin) w_state <= W_RESP;
        end
        W_RESP: if (bvalid) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_outstanding <= 1'b0;
      data_outstanding <= 1'b0;
    end else begin
      if (inst_acc)      inst_outstanding <= 1'b1;
      else if (inst_rsp) inst_outstanding <= 1'b0;
      if (data_rd_acc || data_wr_acc) data_outstanding <= 1'b1;
      else if (data_sram_data_ok)     data_outstanding <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the bench plays the core and a hand-driven AXI slave.
module tb_sram_axi_bridge;
  logic        clk = 1'b0, resetn = 1'b0;
  logic        inst_sram_req = 0, inst_sram_wr = 0;
  logic [1:0]  inst_sram_size = 0;
  logic [3:0]  inst_sram_wstrb = 0;
  logic [31:0] inst_sram_addr = 0, inst_sram_wdata = 0;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req = 0, data_sram_wr = 0;
  logic [1:0]  data_sram_size = 0;
  logic [3:0]  data_sram_wstrb = 0;
  logic [31:0] data_sram_addr = 0, data_sram_wdata = 0;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, awid, wid, arcache, awcache, wstrb;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock;
  logic        arvalid, awvalid, wvalid, wlast, rready, bready;
  logic        arready = 0, awready = 0, wready = 0, rvalid = 0, rlast = 1, bvalid = 0;
  logic [3:0]  rid = 0, bid = 0;
  logic [31:0] rdata = 0;
  logic [1:0]  rresp = 0, bresp = 0;

  int total = 0, fails = 0;

  sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #2; mid();
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_awvalid", 32'(awvalid), 0);
    chk("rst_wvalid", 32'(wvalid), 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_ready_ties", {30'd0, rready, bready}, 32'd3);
    chk("rst_tieoffs", {arburst, awburst, arlen, awlen}, 32'h0005_0000);
    chk("rst_ids", {24'd0, wid, 3'd0, wlast}, 32'h0000_0011);
    resetn = 1'b1;
    step();

    // Inst read, earliest slave
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0000; inst_sram_size = 2'd2;
    mid();
    chk("i0_addr_ok", 32'(inst_sram_addr_ok), 1);
    chk("i0_data_addr_ok", 32'(data_sram_addr_ok), 0);
    step();
    inst_sram_req = 0; arready = 1;
    mid();
    chk("i0_arvalid", 32'(arvalid), 1);
    chk("i0_araddr", araddr, 32'h1c00_0000);
    chk("i0_arid", 32'(arid), 0);
    chk("i0_arsize", 32'(arsize), 2);
    step();
    arready = 0; rvalid = 1; rid = 0; rdata = 32'h0280_0c0c;
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0004;
    mid();
    chk("i0_data_ok", 32'(inst_sram_data_ok), 1);
    chk("i0_rdata", inst_sram_rdata, 32'h0280_0c0c);
    chk("i0_d_data_ok", 32'(data_sram_data_ok), 0);
    chk("i0_arvalid_low", 32'(arvalid), 0);
    chk("i_no_reuse_same_cycle", 32'(inst_sram_addr_ok), 0);
    step();

    // Simultaneous inst and data read: data wins
    rvalid = 0;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_1000; data_sram_size = 2'd2;
    mid();
    chk("arb_data_ok", 32'(data_sram_addr_ok), 1);
    chk("arb_inst_held", 32'(inst_sram_addr_ok), 0);
    step();
    data_sram_req = 0; arready = 1;
    mid();
    chk("arb_arid_data", 32'(arid), 1);
    chk("arb_araddr_data", araddr, 32'h0000_1000);
    chk("arb_inst_busy", 32'(inst_sram_addr_ok), 0);
    step();
    arready = 0;
    mid();
    chk("arb_inst_next", 32'(inst_sram_addr_ok), 1);
    step();
    inst_sram_req = 0; arready = 1;
    mid();
    chk("arb_arid_inst", 32'(arid), 0);
    chk("arb_araddr_inst", araddr, 32'h1c00_0004);
    step();

    // Out-of-order responses: data first, then a foreign id, then inst
    arready = 0; rvalid = 1; rid = 1; rdata = 32'h1111_1111;
    mid();
    chk("ooo_d_ok", 32'(data_sram_data_ok), 1);
    chk("ooo_d_rdata", data_sram_rdata, 32'h1111_1111);
    chk("ooo_i_quiet", 32'(inst_sram_data_ok), 0);
    step();
    rid = 3; rdata = 32'h3333_3333;
    mid();
    chk("bad_id_ignored", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 0);
    step();
    rid = 0; rdata = 32'h2222_2222;
    mid();
    chk("ooo_i_ok", 32'(inst_sram_data_ok), 1);
    chk("ooo_i_rdata", inst_sram_rdata, 32'h2222_2222);
    chk("ooo_d_quiet", 32'(data_sram_data_ok), 0);
    step();

    // Write: wready well before awready
    rvalid = 0;
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h0000_2000;
    data_sram_wdata = 32'hdead_beef; data_sram_wstrb = 4'b0011; data_sram_size = 2'd2;
    mid();
    chk("w_addr_ok", 32'(data_sram_addr_ok), 1);
    step();
    data_sram_req = 0; data_sram_wr = 0; wready = 1;
    mid();
    chk("w_awvalid", 32'(awvalid), 1);
    chk("w_wvalid", 32'(wvalid), 1);
    chk("w_awaddr", awaddr, 32'h0000_2000);
    chk("w_wdata", wdata, 32'hdead_beef);
    chk("w_wstrb", 32'(wstrb), 32'h3);
    chk("w_awsize", 32'(awsize), 2);
    chk("w_awid", 32'(awid), 1);
    step();
    wready = 0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("w_aw_hold", {30'd0, awvalid, wvalid}, 32'h2);
      chk("w_no_early_ok", 32'(data_sram_data_ok), 0);
      if (i < 2) step();
      else awready = 1;
    end
    step();
    awready = 0;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_3000;
    mid();
    chk("w_resp_valids_low", {30'd0, awvalid, wvalid}, 0);
    chk("w_resp_rd_blocked", 32'(data_sram_addr_ok), 0);
    chk("w_resp_wait", 32'(data_sram_data_ok), 0);
    step();
    bvalid = 1;
    mid();
    chk("w_data_ok", 32'(data_sram_data_ok), 1);
    chk("w_bvalid_rd_blocked", 32'(data_sram_addr_ok), 0);
    step();
    bvalid = 0;
    mid();
    chk("w_single_data_ok", 32'(data_sram_data_ok), 0);
    chk("rd_after_w_ok", 32'(data_sram_addr_ok), 1);
    step();
    data_sram_req = 0;
    mid();
    chk("rd_after_w_arvalid", 32'(arvalid), 1);
    chk("rd_after_w_araddr", araddr, 32'h0000_3000);

    // Reset in AR_BUSY
    #1 resetn = 0;
    #1;
    chk("rst_mid_arvalid", 32'(arvalid), 0);
    chk("rst_mid_araddr", araddr, 0);
    #1 resetn = 1;
    step();
    data_sram_req = 1; data_sram_addr = 32'h0000_4000;
    mid();
    chk("post_rst_addr_ok", 32'(data_sram_addr_ok), 1);
    step();
    data_sram_req = 0; arready = 1;
    mid();
    chk("post_rst_araddr", araddr, 32'h0000_4000);
    step();
    arready = 0; rvalid = 1; rid = 1; rdata = 32'h4444_4444;
    mid();
    chk("post_rst_data_ok", 32'(data_sram_data_ok), 1);
    chk("post_rst_rdata", data_sram_rdata, 32'h4444_4444);
    step();
    rvalid = 0;

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
